// File: rtl/multi_sensor_speed_meter.sv
// Multi-sensor lane speed meter: timestamps each sensor's rising edge in ms
// and divides 360*gap_cm by the per-segment ms delta to get 0.1 km/h units.
module multi_sensor_speed_meter #(
  parameter int unsigned SYS_FREQ    = 50000000,
  parameter int unsigned NUM_SENSORS = 3,
  parameter logic [16*(NUM_SENSORS-1)-1:0] GAP_CM = {16'd600, 16'd400},
  parameter int unsigned WIDTH_MS    = 16,
  parameter int unsigned WIDTH_SPEED = 14,
  parameter int unsigned SPEED_LIMIT = 600,
  parameter int unsigned TIMEOUT_MS  = 10000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SENSORS-1:0]         sensor,
  output logic [WIDTH_SPEED-1:0]         speed,
  output logic [$clog2(NUM_SENSORS)-1:0] seg_idx,
  output logic                           speed_valid,
  output logic                           overspeed,
  output logic                           done,
  output logic                           timeout,
  output logic                           busy
);

  localparam int unsigned DIV   = SYS_FREQ / 1000;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned NUM_W = 25;
  localparam int unsigned CNT_W = $clog2(NUM_W + 1);
  localparam int unsigned SEG_W = $clog2(NUM_SENSORS);
  localparam int unsigned IDX_W = $clog2(NUM_SENSORS + 1);
  localparam int unsigned NSEG  = NUM_SENSORS - 1;

  typedef enum logic {IDLE, MEASURE} state_t;

  // ---------------- input synchronisers and edge detect ----------------
  logic [NUM_SENSORS-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [NUM_SENSORS-1:0] cap;

  // 2-FF synchroniser plus a third stage for rising-edge detection
  always_comb begin
    sync1_d = sensor;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    cap     = sync2_q & ~prev_q;
  end

  // ---------------- millisecond timebase ----------------
  logic [PRE_W-1:0]    pre_q, pre_d, pre_inc;
  logic [WIDTH_MS-1:0] ms_q, ms_d, ms_inc;
  logic                start_veh;

  // prescaler wrap advances the saturating ms counter
  always_comb begin
    pre_inc = pre_q + 1'b1;
    ms_inc  = ms_q;
    if (pre_q == PRE_W'(DIV - 1)) begin
      pre_inc = '0;
      if (ms_q != '1) ms_inc = ms_q + 1'b1;
    end
  end

  // timebase restarts on an accepted sensor 0 capture
  always_comb begin
    pre_d = start_veh ? '0 : pre_inc;
    ms_d  = start_veh ? '0 : ms_inc;
  end

  // ---------------- measurement FSM ----------------
  state_t                             state_q, state_d;
  logic [IDX_W-1:0]                   next_q, next_d;
  logic [NUM_SENSORS-1:0][WIDTH_MS-1:0] ts_q, ts_d;
  logic                               busy_q, busy_d, timeout_q, timeout_d;
  logic                               abort, accept, accept_last;
  logic [NSEG-1:0]                    pend_set;
  logic                               done_q;

  // sequence sensors in order; abort when the ms budget runs out
  always_comb begin
    state_d     = state_q;
    next_d      = next_q;
    ts_d        = ts_q;
    busy_d      = busy_q;
    timeout_d   = 1'b0;
    start_veh   = 1'b0;
    abort       = 1'b0;
    accept      = 1'b0;
    accept_last = 1'b0;
    pend_set    = '0;
    case (state_q)
      IDLE: begin
        if (cap[0]) begin
          start_veh = 1'b1;
          ts_d[0]   = '0;
          next_d    = IDX_W'(1);
          busy_d    = 1'b1;
          state_d   = MEASURE;
        end
      end
      MEASURE: begin
        for (int unsigned i = 1; i < NUM_SENSORS; i++) begin
          if (next_q == IDX_W'(i) && cap[i]) begin
            accept        = 1'b1;
            ts_d[i]       = ms_inc;
            pend_set[i-1] = 1'b1;
            if (i == NUM_SENSORS - 1) accept_last = 1'b1;
          end
        end
        if (accept) next_d = next_q + 1'b1;
        if (done_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (ms_q == WIDTH_MS'(TIMEOUT_MS) &&
                     next_q != IDX_W'(NUM_SENSORS) && !accept_last) begin
          // the last-sensor capture wins a tie with the timeout
          timeout_d = 1'b1;
          abort     = 1'b1;
          busy_d    = 1'b0;
          pend_set  = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- sequential divider and result registers ----------------
  logic [NSEG-1:0]        pend_q, pend_d;
  logic                   dbusy_q, dbusy_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_W-1:0]       quo_q, quo_d;
  logic [WIDTH_MS-1:0]    rem_q, rem_d, den_q, den_d;
  logic [SEG_W-1:0]       dseg_q, dseg_d, seg_q, seg_d;
  logic [WIDTH_SPEED-1:0] speed_q, speed_d;
  logic                   valid_q, valid_d, done_d, ovs_q, ovs_d;

  // serve lowest pending segment; restoring divide, one quotient bit per cycle
  always_comb begin
    logic                   found;
    logic [SEG_W-1:0]       sel;
    logic [15:0]            gap;
    logic [WIDTH_MS-1:0]    den_sel;
    logic [WIDTH_MS:0]      rem_sh;
    logic                   qbit;
    logic [NUM_W-1:0]       quo_nx;
    logic [WIDTH_SPEED-1:0] sat;

    pend_d  = pend_q;
    dbusy_d = dbusy_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    den_d   = den_q;
    dseg_d  = dseg_q;
    seg_d   = seg_q;
    speed_d = speed_q;
    ovs_d   = ovs_q;
    valid_d = 1'b0;
    done_d  = 1'b0;

    found   = 1'b0;
    sel     = '0;
    gap     = '0;
    den_sel = '0;
    for (int unsigned i = 0; i < NSEG; i++) begin
      if (pend_q[i] && !found) begin
        found   = 1'b1;
        sel     = SEG_W'(i);
        gap     = GAP_CM[16*i +: 16];
        den_sel = ts_q[i+1] - ts_q[i];
      end
    end

    rem_sh = {rem_q, quo_q[NUM_W-1]};
    qbit   = (rem_sh >= {1'b0, den_q});
    quo_nx = {quo_q[NUM_W-2:0], qbit};
    if (den_q == '0 || |quo_nx[NUM_W-1:WIDTH_SPEED]) sat = '1;
    else                                              sat = quo_nx[WIDTH_SPEED-1:0];

    if (dbusy_q) begin
      rem_d = qbit ? WIDTH_MS'(rem_sh - {1'b0, den_q}) : rem_sh[WIDTH_MS-1:0];
      quo_d = quo_nx;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        dbusy_d = 1'b0;
        valid_d = 1'b1;
        seg_d   = dseg_q;
        speed_d = sat;
        ovs_d   = ovs_q | (sat > WIDTH_SPEED'(SPEED_LIMIT));
        done_d  = (dseg_q == SEG_W'(NSEG - 1));
      end
    end else if (found) begin
      dbusy_d     = 1'b1;
      cnt_d       = CNT_W'(NUM_W);
      quo_d       = NUM_W'(360) * NUM_W'(gap);
      rem_d       = '0;
      den_d       = den_sel;
      dseg_d      = sel;
      pend_d[sel] = 1'b0;
    end

    pend_d = pend_d | pend_set;

    if (abort) begin
      pend_d  = '0;
      dbusy_d = 1'b0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      seg_d   = seg_q;
      speed_d = speed_q;
      ovs_d   = ovs_q;
    end
    if (start_veh) ovs_d = 1'b0;
  end

  // state register for every block above
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      pre_q     <= '0;
      ms_q      <= '0;
      state_q   <= IDLE;
      next_q    <= '0;
      ts_q      <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      pend_q    <= '0;
      dbusy_q   <= 1'b0;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      den_q     <= '0;
      dseg_q    <= '0;
      seg_q     <= '0;
      speed_q   <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      ovs_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      pre_q     <= pre_d;
      ms_q      <= ms_d;
      state_q   <= state_d;
      next_q    <= next_d;
      ts_q      <= ts_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      pend_q    <= pend_d;
      dbusy_q   <= dbusy_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      den_q     <= den_d;
      dseg_q    <= dseg_d;
      seg_q     <= seg_d;
      speed_q   <= speed_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      ovs_q     <= ovs_d;
    end
  end

  assign speed       = speed_q;
  assign seg_idx     = seg_q;
  assign speed_valid = valid_q;
  assign overspeed   = ovs_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_multi_sensor_speed_meter.sv
// Scoreboard bench: stimulus pushes expected results computed from the
// distance/time rules; per-instance monitors pop and compare on each output.
module tb_multi_sensor_speed_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_a, rst_b;
  logic [2:0]  sen_a, sen_b;
  logic [13:0] spd_a, spd_b;
  logic [1:0]  seg_a, seg_b;
  logic        sv_a, sv_b, ov_a, ov_b, dn_a, dn_b, to_a, to_b, bz_a, bz_b;

  // instance A: 1 cycle per ms, short timeout
  multi_sensor_speed_meter #(
    .SYS_FREQ(1000), .NUM_SENSORS(3), .GAP_CM({16'd600, 16'd400}),
    .WIDTH_MS(16), .WIDTH_SPEED(14), .SPEED_LIMIT(600), .TIMEOUT_MS(2000)
  ) dut_a (
    .clk(clk), .reset(rst_a), .sensor(sen_a), .speed(spd_a), .seg_idx(seg_a),
    .speed_valid(sv_a), .overspeed(ov_a), .done(dn_a), .timeout(to_a), .busy(bz_a)
  );

  // instance B: 50 MHz clock, 50000 cycles per ms
  multi_sensor_speed_meter #(
    .SYS_FREQ(50000000), .NUM_SENSORS(3), .GAP_CM({16'd600, 16'd400}),
    .WIDTH_MS(16), .WIDTH_SPEED(14), .SPEED_LIMIT(600), .TIMEOUT_MS(10000)
  ) dut_b (
    .clk(clk), .reset(rst_b), .sensor(sen_b), .speed(spd_b), .seg_idx(seg_b),
    .speed_valid(sv_b), .overspeed(ov_b), .done(dn_b), .timeout(to_b), .busy(bz_b)
  );

  typedef struct {
    bit tmo;
    int seg;
    int spd;
    bit done;
    bit ovs;
    int at;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int spd_of(input int gap, input int den);
    int q;
    if (den == 0) return 16383;
    q = (360 * gap) / den;
    return (q > 16383) ? 16383 : q;
  endfunction

  function automatic void compare(input string tag, input exp_t e,
                                  input logic sv, input logic to, input logic dn,
                                  input logic ov, input int spd, input int seg);
    chk({tag, "_timeout"}, int'(to), int'(e.tmo));
    chk({tag, "_valid"}, int'(sv), int'(!e.tmo));
    chk({tag, "_done"}, int'(dn), int'(e.done));
    chk({tag, "_cycle"}, cyc, e.at);
    if (!e.tmo) begin
      chk({tag, "_speed"}, spd, e.spd);
      chk({tag, "_seg"}, seg, e.seg);
      chk({tag, "_overspeed"}, int'(ov), int'(e.ovs));
    end
  endfunction

  // monitor A
  always @(negedge clk) begin
    if (!rst_a && (sv_a || to_a || dn_a)) begin
      if (q_a.size() == 0) chk("a_unexpected_output", int'({sv_a, to_a, dn_a}), 0);
      else begin
        ea = q_a.pop_front();
        compare("a", ea, sv_a, to_a, dn_a, ov_a, int'(spd_a), int'(seg_a));
      end
    end
  end

  // monitor B
  always @(negedge clk) begin
    if (!rst_b && (sv_b || to_b || dn_b)) begin
      if (q_b.size() == 0) chk("b_unexpected_output", int'({sv_b, to_b, dn_b}), 0);
      else begin
        eb = q_b.pop_front();
        compare("b", eb, sv_b, to_b, dn_b, ov_b, int'(spd_b), int'(seg_b));
      end
    end
  end

  task automatic at_next();
    @(posedge clk); #1;
  endtask

  task automatic at_cycle(input int t);
    while (1) begin
      @(posedge clk); #1;
      if (cyc >= t) break;
    end
  endtask

  task automatic drive(input int inst, input int idx, input logic v);
    if (inst == 0) sen_a[idx] = v;
    else           sen_b[idx] = v;
  endtask

  task automatic push(input int inst, input exp_t e);
    if (inst == 0) q_a.push_back(e);
    else           q_b.push_back(e);
  endtask

  function automatic int qsize(input int inst);
    return (inst == 0) ? q_a.size() : q_b.size();
  endfunction

  function automatic int busy_of(input int inst);
    return (inst == 0) ? int'(bz_a) : int'(bz_b);
  endfunction

  function automatic int ovs_of(input int inst);
    return (inst == 0) ? int'(ov_a) : int'(ov_b);
  endfunction

  // wait for outstanding results, confirm idle, release all sensors
  task automatic finish_vehicle(input int inst);
    int guard;
    guard = 0;
    while (qsize(inst) != 0 && guard < 6000) begin
      @(posedge clk);
      guard++;
    end
    chk("drain", qsize(inst), 0);
    if (inst == 0) q_a.delete(); else q_b.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("busy_after", busy_of(inst), 0);
    if (inst == 0) sen_a = '0; else sen_b = '0;
    repeat (6) @(posedge clk);
  endtask

  // one vehicle: sensor 0, then sensor 1 after d01 cycles, then sensor 2 after d12
  task automatic vehicle(input int inst, input int d01, input int d12, input bit send2);
    int div, t0, t1, t2, ts1, ts2, s0v, s1v, v0, v1;
    bit ov;
    div = (inst == 0) ? 1 : 50000;
    at_next();
    drive(inst, 0, 1'b1);
    t0 = cyc;
    at_cycle(t0 + 3);
    @(negedge clk);
    chk("busy_on_capture", busy_of(inst), 1);
    chk("overspeed_cleared", ovs_of(inst), 0);
    at_cycle(t0 + d01);
    drive(inst, 1, 1'b1);
    t1  = cyc;
    ts1 = d01 / div;
    s0v = spd_of(400, ts1);
    ov  = (s0v > 600);
    v0  = t1 + 29;
    push(inst, '{tmo: 1'b0, seg: 0, spd: s0v, done: 1'b0, ovs: ov, at: v0});
    if (send2) begin
      at_cycle(t1 + d12);
      drive(inst, 2, 1'b1);
      t2  = cyc;
      ts2 = (d01 + d12) / div;
      s1v = spd_of(600, ts2 - ts1);
      ov  = ov | (s1v > 600);
      v1  = (t2 + 29 > v0 + 26) ? t2 + 29 : v0 + 26;
      push(inst, '{tmo: 1'b0, seg: 1, spd: s1v, done: 1'b1, ovs: ov, at: v1});
    end else begin
      push(inst, '{tmo: 1'b1, seg: 0, spd: 0, done: 1'b0, ovs: 1'b0,
                   at: t0 + 3 + 2000 * div + 1});
    end
    finish_vehicle(inst);
  endtask

  initial begin
    int t0, t1, t2;
    rst_a = 1'b1;
    rst_b = 1'b1;
    sen_a = '0;
    sen_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a_speed", int'(spd_a), 0);
    chk("reset_a_flags", int'({sv_a, ov_a, dn_a, to_a, bz_a, seg_a}), 0);
    chk("reset_b_speed", int'(spd_b), 0);
    chk("reset_b_flags", int'({sv_b, ov_b, dn_b, to_b, bz_b, seg_b}), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (5) @(posedge clk);

    // nominal, overspeed, timeout on A
    vehicle(0, 640, 960, 1'b1);
    vehicle(0, 640, 300, 1'b1);
    vehicle(0, 640, 0, 1'b0);

    // retriggered sensor 0 and early sensor 2 must be ignored
    at_next();
    sen_a[0] = 1'b1;
    t0 = cyc;
    at_cycle(t0 + 100); sen_a[0] = 1'b0;
    at_cycle(t0 + 150); sen_a[0] = 1'b1;
    at_cycle(t0 + 200); sen_a[2] = 1'b1;
    at_cycle(t0 + 400); sen_a[1] = 1'b1;
    t1 = cyc;
    push(0, '{tmo: 1'b0, seg: 0, spd: spd_of(400, 400), done: 1'b0, ovs: 1'b0, at: t1 + 29});
    at_cycle(t0 + 500); sen_a[2] = 1'b0;
    at_cycle(t0 + 700); sen_a[2] = 1'b1;
    t2 = cyc;
    push(0, '{tmo: 1'b0, seg: 1, spd: spd_of(600, 300), done: 1'b1, ovs: 1'b1, at: t2 + 29});
    finish_vehicle(0);

    // reset 100 ms into a measurement: silent abort, then a clean vehicle
    at_next();
    sen_a[0] = 1'b1;
    t0 = cyc;
    at_cycle(t0 + 103);
    rst_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_speed", int'(spd_a), 0);
    chk("midreset_flags", int'({sv_a, ov_a, dn_a, to_a, bz_a, seg_a}), 0);
    rst_a = 1'b0;
    sen_a = '0;
    repeat (2100) @(posedge clk);
    @(negedge clk);
    chk("midreset_idle", int'(bz_a), 0);
    vehicle(0, 640, 960, 1'b1);

    // random vehicles on A
    for (int i = 0; i < 6; i++)
      vehicle(0, int'($urandom_range(900, 20)), int'($urandom_range(900, 20)), 1'b1);

    // B: captures within one ms give zero denominators; seg1 queued behind seg0
    vehicle(1, 10, 5, 1'b1);
    for (int i = 0; i < 3; i++)
      vehicle(1, int'($urandom_range(40, 4)), int'($urandom_range(10, 1)), 1'b1);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
